// File: rtl/node_share_sched.sv
// node_share_sched
// Round-robin scheduler that lets NREQ requesters share one computation node
// with the ST/RD/RES/IN0/IN1 handshake. The winner's operands are registered
// at grant, the node is strobed once, and the result (or a watchdog timeout)
// is returned to the owner with a one-cycle DONE pulse.
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous reset, active low
//   REQ        per-requester request level, held until that requester's DONE
//   A0, A1     packed operands, requester i at [i*WIDTH +: WIDTH]
//   GNT        one-hot owner of the node, zero when idle
//   DONE       one-cycle completion pulse to the owner
//   ERR        valid with DONE, 1 = node timed out and Q is stale
//   Q          result, held until the next successful DONE
//   BUSY       high whenever the scheduler is not idle
//   NST        node start strobe
//   NIN0/NIN1  node operands
//   NRD        node ready level
//   NRES       node result
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no owner; arbitrate among REQ from the round-robin pointer
// START  | NST high for this one cycle
// GUARD  | NRD ignored (may still be high from the previous job)
// WAIT   | wait for NRD, abort after TMO cycles
// RESP   | DONE/ERR presented to the owner

module node_share_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int TMO   = 255
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NREQ-1:0]         REQ,
   input  logic [NREQ*WIDTH-1:0]   A0,
   input  logic [NREQ*WIDTH-1:0]   A1,
   output logic [NREQ-1:0]         GNT,
   output logic [NREQ-1:0]         DONE,
   output logic                    ERR,
   output logic [WIDTH-1:0]        Q,
   output logic                    BUSY,
   output logic                    NST,
   output logic [WIDTH-1:0]        NIN0,
   output logic [WIDTH-1:0]        NIN1,
   input  logic                    NRD,
   input  logic [WIDTH-1:0]        NRES
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [CW-1:0] CNT_TERM = CW'(TMO - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_GUARD,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [PW-1:0]     ptr;
   logic [CW-1:0]     cnt;
   logic              win_found;
   logic [PW-1:0]     win_idx;
   logic [WIDTH-1:0]  a0_arr [NREQ];
   logic [WIDTH-1:0]  a1_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a0_arr[g] = A0[g*WIDTH +: WIDTH];
      assign a1_arr[g] = A1[g*WIDTH +: WIDTH];
   end

   // First set request at or after ptr, wrapping modulo NREQ.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         cand = sum[PW-1:0];
         if (!win_found && REQ[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (win_found) state_next = S_START;
         S_START: state_next = S_GUARD;
         S_GUARD: state_next = S_WAIT;
         S_WAIT:  if (NRD || (cnt == CNT_TERM)) state_next = S_RESP;
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
         ptr   <= '0;
         cnt   <= '0;
         GNT   <= '0;
         DONE  <= '0;
         ERR   <= 1'b0;
         Q     <= '0;
         BUSY  <= 1'b0;
         NST   <= 1'b0;
         NIN0  <= '0;
         NIN1  <= '0;
      end else begin
         state <= state_next;
         BUSY  <= (state_next != S_IDLE);
         NST   <= (state_next == S_START);
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  GNT  <= NREQ'(1) << win_idx;
                  NIN0 <= a0_arr[win_idx];
                  NIN1 <= a1_arr[win_idx];
                  ptr  <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
               end
            end
            S_GUARD: cnt <= '0;
            S_WAIT: begin
               // A ready node wins over a coincident timeout.
               if (NRD) begin
                  Q    <= NRES;
                  ERR  <= 1'b0;
                  DONE <= GNT;
               end else if (cnt == CNT_TERM) begin
                  ERR  <= 1'b1;
                  DONE <= GNT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESP: begin
               GNT  <= '0;
               DONE <= '0;
               ERR  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   gnt_onehot_a:  assert property (@(posedge CLK) disable iff (!RST) $onehot0(GNT));
   done_onehot_a: assert property (@(posedge CLK) disable iff (!RST) $onehot0(DONE));

endmodule

// File: tb/tb_node_share_sched.sv
module tb_node_share_sched;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int TMO_T = 8;

   logic            CLK = 1'b0;
   logic            RST;
   logic [N-1:0]    REQ;
   logic [N*W-1:0]  A0, A1;
   logic [N-1:0]    GNT, DONE;
   logic            ERR, BUSY, NST, NRD;
   logic [W-1:0]    Q, NIN0, NIN1, NRES;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int last_done = 0;

   // behavioural model state
   int           m_ptr = 0;
   int           m_last = 0;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] a0_v [N];
   logic [W-1:0] a1_v [N];
   int           waits [N];

   node_share_sched #(.NREQ(N), .WIDTH(W), .TMO(TMO_T)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .A0(A0), .A1(A1),
      .GNT(GNT), .DONE(DONE), .ERR(ERR), .Q(Q), .BUSY(BUSY),
      .NST(NST), .NIN0(NIN0), .NIN1(NIN1), .NRD(NRD), .NRES(NRES)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic pack_ops();
      for (int i = 0; i < N; i++) begin
         A0[i*W +: W] = a0_v[i];
         A1[i*W +: W] = a1_v[i];
      end
   endtask

   task automatic scramble_ops();
      for (int i = 0; i < N; i++) begin
         a0_v[i] = W'($urandom);
         a1_v[i] = W'($urandom);
      end
      pack_ops();
   endtask

   // One complete job, entered in an IDLE cycle with REQ already set and
   // left in the IDLE cycle that follows the DONE cycle.
   // wait_n: WAIT cycles with NRD low before the node answers.
   task automatic do_job(input int wait_n, input logic [W-1:0] res, input bit stale,
                         input bit drop, input bit gap_chk);
      int w, c_done;
      bit exp_err, seen;
      logic [W-1:0] e0, e1;
      w = rr_pick(REQ, m_ptr);
      if (w < 0) begin
         chk("req_nonzero", 0, 1);
         return;
      end
      e0 = a0_v[w];
      e1 = a1_v[w];
      exp_err = (wait_n >= TMO_T);
      c_done  = exp_err ? 2 + TMO_T : 3 + wait_n;
      for (int i = 0; i < N; i++) begin
         if (i == w) continue;
         if (REQ[i]) waits[i]++;
         else waits[i] = 0;
      end
      chk("rr_wait_bound", 64'(waits[w] <= N - 1), 1);
      waits[w] = 0;

      @(posedge CLK); #1;
      chk("gnt", GNT, 64'(1) << w);
      chk("nst_on", NST, 1);
      chk("busy", BUSY, 1);
      chk("nin0", NIN0, e0);
      chk("nin1", NIN1, e1);
      scramble_ops();
      NRD  = stale;
      NRES = 16'hDEAD;

      seen = 0;
      for (int c = 1; c <= 2 + TMO_T + 4 && !seen; c++) begin
         @(posedge CLK); #1;
         if (c >= 2) begin
            NRD  = (c - 2 >= wait_n);
            NRES = NRD ? res : W'($urandom);
         end
         if (drop && c == 3) REQ[w] = 1'b0;
         if (c == 1) chk("nst_off", NST, 0);
         if (DONE != '0) begin
            seen = 1;
            chk("done_cycle", c, c_done);
            chk("done", DONE, 64'(1) << w);
            chk("err", ERR, exp_err);
            if (!exp_err) m_q = res;
            chk("q", Q, m_q);
            chk("nin0_hold", NIN0, e0);
            if (gap_chk) chk("done_gap", cyc - last_done, 5);
            last_done = cyc;
         end
      end
      if (!seen) chk("done_seen", 0, 1);
      m_ptr  = (w + 1) % N;
      m_last = w;

      @(posedge CLK); #1;
      chk("idle_gnt", GNT, 0);
      chk("idle_done", DONE, 0);
      chk("idle_err", ERR, 0);
      chk("idle_busy", BUSY, 0);
   endtask

   initial begin
      int  wn;
      bit  drp;
      RST  = 1'b0;
      REQ  = 4'b1111;
      NRD  = 1'b0;
      NRES = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      scramble_ops();

      // reset held with all requests pending
      repeat (5) begin
         @(posedge CLK); #1;
         chk("rst_outputs", {GNT, DONE, ERR, Q, BUSY, NST, NIN0, NIN1}, 0);
      end
      RST = 1'b1;

      // fairness: all requesting, grants rotate 0,1,2,3,0 every 5 cycles
      for (int j = 0; j < 5; j++) do_job(0, W'($urandom), 0, 0, j > 0);

      // single job on requester 2, node answers 3 cycles after NST
      REQ = 4'b0100;
      a0_v[2] = 16'h0012;
      a1_v[2] = 16'h0034;
      pack_ops();
      do_job(1, 16'h0046, 0, 0, 0);

      // stale ready through START/GUARD
      REQ = 4'b0001;
      NRD = 1'b1;
      do_job(2, 16'hBEEF, 1, 0, 0);

      // node never answers, then a normal job
      REQ = 4'b1000;
      do_job(20, 16'hCAFE, 0, 0, 0);
      do_job(0, 16'h7777, 0, 0, 0);

      // answer on the last allowed WAIT cycle
      REQ = 4'b0001;
      do_job(TMO_T - 1, 16'h0A0A, 0, 0, 0);

      // owner withdraws mid-WAIT
      REQ = 4'b0010;
      do_job(4, 16'h1234, 0, 1, 0);

      // reset during WAIT abandons the job
      REQ = 4'b0010;
      NRD = 1'b0;
      @(posedge CLK); #1;
      chk("ab_gnt", GNT, 4'b0010);
      repeat (3) @(posedge CLK);
      #1;
      chk("ab_busy_pre", BUSY, 1);
      RST = 1'b0;
      #1;
      chk("ab_async", {GNT, BUSY, NST, DONE}, 0);
      REQ = '0;
      repeat (3) begin
         @(posedge CLK); #1;
         chk("ab_hold", {GNT, DONE, NST, BUSY}, 0);
      end
      RST = 1'b1;
      m_ptr = 0;
      m_q   = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      repeat (4) begin
         @(posedge CLK); #1;
         chk("ab_quiet", {NST, GNT, DONE, Q}, 0);
      end

      // randomized traffic; only the winner may drop its request
      for (int j = 0; j < 60; j++) begin
         if (j > 0 && $urandom_range(0, 1) == 1) REQ[m_last] = 1'b0;
         REQ = REQ | N'($urandom_range(0, 15));
         if (REQ == '0) REQ = N'(1) << $urandom_range(0, N - 1);
         wn  = $urandom_range(0, 10);
         drp = (wn >= 2) && ($urandom_range(0, 7) == 0);
         do_job(wn, W'($urandom), 1'($urandom_range(0, 1)), drp, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
